// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and transaction owner.
// Used by mem_port_arbiter and mem_arb_prio (MEM_ARB_ROUND_ROBIN_EN aware).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between the IF and DM requesters. Fixed DM-over-IF priority by
// default; defining MEM_ARB_ROUND_ROBIN_EN adds an alternating preference pointer.
module mem_arb_prio
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
`endif
    input  logic if_req,
    input  logic dm_req,
    output logic dm_wins
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t pref;

    // Preference flips to whoever lost each grant, so a held pair alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            pref <= OWN_DM;
        end else if (take) begin
            pref <= dm_wins ? OWN_IF : OWN_DM;
        end
    end

    always_comb begin
        dm_wins = dm_req || !if_req;
        if (if_req && dm_req) begin
            dm_wins = (pref == OWN_DM);
        end
    end
`else
    assign dm_wins = dm_req || !if_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF, DM) arbiter for one shared memory port, one transaction in flight.
// Optional MEM_ARB_ROUND_ROBIN_EN switches tie-break from fixed DM priority to round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_RVALID,
    output logic [DW-1:0] IF_RDATA,

    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WDATA,
    output logic          DM_GNT,
    output logic          DM_RVALID,
    output logic [DW-1:0] DM_RDATA,

    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,

    output logic          BUSY
);

    localparam logic [1:0] LAST_WAIT = 2'(MEM_LATENCY - 1);

    arb_state_t    state;
    owner_t        owner;
    owner_t        winner;
    logic [1:0]    cnt;
    logic          lat_we;
    logic          dm_wins;
    logic          grant;
    logic          if_rvalid_q;
    logic          dm_rvalid_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic [DW-1:0] resp_data;

    mem_arb_prio u_prio (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk     (CLK),
        .rst     (RST),
        .take    (grant),
`endif
        .if_req  (IF_REQ),
        .dm_req  (DM_REQ),
        .dm_wins (dm_wins)
    );

    assign grant  = (state == IDLE) && !RST && (IF_REQ || DM_REQ);
    assign winner = dm_wins ? OWN_DM : OWN_IF;
    assign IF_GNT = grant && (winner == OWN_IF);
    assign DM_GNT = grant && (winner == OWN_DM);
    assign BUSY   = (state != IDLE);

    // Memory data is valid in the RESP cycle itself, so it is passed straight through
    // while RVALID is high and held in the per-owner register afterwards.
    assign resp_data = lat_we ? '0 : MEM_RDATA;
    assign IF_RVALID = if_rvalid_q;
    assign DM_RVALID = dm_rvalid_q;
    assign IF_RDATA  = if_rvalid_q ? resp_data : if_rdata_q;
    assign DM_RDATA  = dm_rvalid_q ? resp_data : dm_rdata_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            owner       <= OWN_DM;
            cnt         <= '0;
            lat_we      <= 1'b0;
            MEM_EN      <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_WDATA   <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            MEM_EN      <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_WDATA   <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        state  <= ISSUE;
                        owner  <= winner;
                        MEM_EN <= 1'b1;
                        if (winner == OWN_DM) begin
                            lat_we    <= DM_WE;
                            MEM_WE    <= DM_WE;
                            MEM_ADDR  <= DM_ADDR;
                            MEM_WDATA <= DM_WDATA;
                        end else begin
                            lat_we   <= 1'b0;
                            MEM_ADDR <= IF_ADDR;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= 2'd1;
                    if (MEM_LATENCY == 1) begin
                        state       <= RESP;
                        if_rvalid_q <= (owner == OWN_IF);
                        dm_rvalid_q <= (owner == OWN_DM);
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAST_WAIT) begin
                        state       <= RESP;
                        if_rvalid_q <= (owner == OWN_IF);
                        dm_rvalid_q <= (owner == OWN_DM);
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    cnt   <= '0;
                    if (owner == OWN_IF) begin
                        if_rdata_q <= resp_data;
                    end else begin
                        dm_rdata_q <= resp_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at 3,
// each with its own behavioural memory; optional MEM_ARB_ROUND_ROBIN_EN changes expected grant order.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK;
    logic          rst       [2];
    logic          if_req    [2];
    logic [AW-1:0] if_addr   [2];
    logic          if_gnt    [2];
    logic          if_rvalid [2];
    logic [DW-1:0] if_rdata  [2];
    logic          dm_req    [2];
    logic          dm_we     [2];
    logic [AW-1:0] dm_addr   [2];
    logic [DW-1:0] dm_wdata  [2];
    logic          dm_gnt    [2];
    logic          dm_rvalid [2];
    logic [DW-1:0] dm_rdata  [2];
    logic          mem_en    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          busy      [2];

    int            checks = 0;
    int            errors = 0;
    int            lat [2] = '{1, 3};
    logic [DW-1:0] shadow [2][1024];

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h0000_0513;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    mem_port_arbiter #(.MEM_LATENCY(1), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(rst[0]),
        .IF_REQ(if_req[0]), .IF_ADDR(if_addr[0]), .IF_GNT(if_gnt[0]),
        .IF_RVALID(if_rvalid[0]), .IF_RDATA(if_rdata[0]),
        .DM_REQ(dm_req[0]), .DM_WE(dm_we[0]), .DM_ADDR(dm_addr[0]), .DM_WDATA(dm_wdata[0]),
        .DM_GNT(dm_gnt[0]), .DM_RVALID(dm_rvalid[0]), .DM_RDATA(dm_rdata[0]),
        .MEM_EN(mem_en[0]), .MEM_WE(mem_we[0]), .MEM_ADDR(mem_addr[0]),
        .MEM_WDATA(mem_wdata[0]), .MEM_RDATA(mem_rdata[0]), .BUSY(busy[0])
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .AW(AW), .DW(DW)) dut3 (
        .CLK(CLK), .RST(rst[1]),
        .IF_REQ(if_req[1]), .IF_ADDR(if_addr[1]), .IF_GNT(if_gnt[1]),
        .IF_RVALID(if_rvalid[1]), .IF_RDATA(if_rdata[1]),
        .DM_REQ(dm_req[1]), .DM_WE(dm_we[1]), .DM_ADDR(dm_addr[1]), .DM_WDATA(dm_wdata[1]),
        .DM_GNT(dm_gnt[1]), .DM_RVALID(dm_rvalid[1]), .DM_RDATA(dm_rdata[1]),
        .MEM_EN(mem_en[1]), .MEM_WE(mem_we[1]), .MEM_ADDR(mem_addr[1]),
        .MEM_WDATA(mem_wdata[1]), .MEM_RDATA(mem_rdata[1]), .BUSY(busy[1])
    );

    // Synchronous memory: read data valid exactly LAT cycles after the MEM_EN cycle,
    // random junk on the bus at every other time.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem [1024];
        logic          pv  [LAT];
        logic [DW-1:0] pd  [LAT];
        logic [DW-1:0] junk;

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
            for (int i = 0; i < LAT; i++) begin
                pv[i] = 1'b0;
                pd[i] = '0;
            end
            junk = 32'hDEAD_BEEF;
        end

        always @(posedge CLK) begin
            junk <= $urandom;
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g][9:0]] <= mem_wdata[g];
            pv[0] <= mem_en[g] && !mem_we[g];
            pd[0] <= mem[mem_addr[g][9:0]];
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end

        assign mem_rdata[g] = pv[LAT-1] ? pd[LAT-1] : junk;
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs(input int k);
        if_req[k]   = 1'b0;
        if_addr[k]  = '0;
        dm_req[k]   = 1'b0;
        dm_we[k]    = 1'b0;
        dm_addr[k]  = '0;
        dm_wdata[k] = '0;
    endtask

    task automatic do_reset(input int k);
        idle_inputs(k);
        rst[k] = 1'b1;
        step();
        rst[k] = 1'b0;
    endtask

    task automatic test_reset(input int k);
        idle_inputs(k);
        rst[k] = 1'b1;
        if_req[k] = 1'b1;
        dm_req[k] = 1'b1;
        step();
        @(negedge CLK);
        checks++;
        if ({if_gnt[k], dm_gnt[k]} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_gnt k=%0d got=%b exp=00", k, {if_gnt[k], dm_gnt[k]});
        end
        checks++;
        if ({mem_en[k], mem_we[k], busy[k]} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl k=%0d en/we/busy got=%b exp=000", k, {mem_en[k], mem_we[k], busy[k]});
        end
        checks++;
        if ({if_rvalid[k], dm_rvalid[k]} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_rvalid k=%0d got=%b exp=00", k, {if_rvalid[k], dm_rvalid[k]});
        end
        checks++;
        if (if_rdata[k] !== '0 || dm_rdata[k] !== '0 || mem_addr[k] !== '0 || mem_wdata[k] !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data k=%0d if=%h dm=%h addr=%h wdata=%h exp=0", k,
                     if_rdata[k], dm_rdata[k], mem_addr[k], mem_wdata[k]);
        end
        step();
        do_reset(k);
    endtask

    task automatic test_if_fetch();
        do_reset(0);
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h10;
        @(negedge CLK);
        checks++;
        if ({if_gnt[0], dm_gnt[0]} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL fetch_gnt got=%b exp=10", {if_gnt[0], dm_gnt[0]});
        end
        step();
        idle_inputs(0);
        @(negedge CLK);
        checks++;
        if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b0 || mem_addr[0] !== 32'h10) begin
            errors++;
            $display("[TB] FAIL fetch_issue en=%b we=%b addr=%h exp en=1 we=0 addr=10",
                     mem_en[0], mem_we[0], mem_addr[0]);
        end
        step();
        @(negedge CLK);
        checks++;
        if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== 32'h0000_0513) begin
            errors++;
            $display("[TB] FAIL fetch_resp rvalid=%b rdata=%h exp rvalid=1 rdata=00000513",
                     if_rvalid[0], if_rdata[0]);
        end
        step();
        @(negedge CLK);
        checks++;
        if (if_rvalid[0] !== 1'b0 || if_rdata[0] !== 32'h0000_0513 || busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_hold rvalid=%b rdata=%h busy=%b exp 0/00000513/0",
                     if_rvalid[0], if_rdata[0], busy[0]);
        end
        step();
    endtask

    task automatic test_priority();
        do_reset(0);
        if_req[0]   = 1'b1;
        if_addr[0]  = 32'h40;
        dm_req[0]   = 1'b1;
        dm_we[0]    = 1'b1;
        dm_addr[0]  = 32'h1F4;
        dm_wdata[0] = 32'hA5;
        @(negedge CLK);
        checks++;
        if ({if_gnt[0], dm_gnt[0]} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL prio_gnt if/dm got=%b exp=01", {if_gnt[0], dm_gnt[0]});
        end
        step();
        dm_req[0] = 1'b0;
        dm_we[0]  = 1'b0;
        shadow[0][10'h1F4] = 32'hA5;
        @(negedge CLK);
        checks++;
        if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h1F4 ||
            mem_wdata[0] !== 32'hA5 || if_gnt[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_store en=%b we=%b addr=%h wdata=%h ifgnt=%b exp 1/1/1f4/a5/0",
                     mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], if_gnt[0]);
        end
        step();
        @(negedge CLK);
        checks++;
        if (dm_rvalid[0] !== 1'b1 || dm_rdata[0] !== '0 || if_gnt[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_ack rvalid=%b rdata=%h ifgnt=%b exp 1/0/0",
                     dm_rvalid[0], dm_rdata[0], if_gnt[0]);
        end
        step();
        @(negedge CLK);
        checks++;
        if (if_gnt[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_if_after got=%b exp=1", if_gnt[0]);
        end
        step();
        if_req[0] = 1'b0;
        @(negedge CLK);
        checks++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h40) begin
            errors++;
            $display("[TB] FAIL prio_if_issue en=%b addr=%h exp 1/40", mem_en[0], mem_addr[0]);
        end
        step();
        @(negedge CLK);
        checks++;
        if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== shadow[0][10'h40]) begin
            errors++;
            $display("[TB] FAIL prio_if_resp rvalid=%b rdata=%h exp 1/%h",
                     if_rvalid[0], if_rdata[0], shadow[0][10'h40]);
        end
        step();
    endtask

    task automatic test_round_robin();
        bit found;
        bit exp_dm;
        do_reset(0);
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h44;
        dm_req[0]  = 1'b1;
        dm_we[0]   = 1'b0;
        dm_addr[0] = 32'h48;
        for (int n = 0; n < 4; n++) begin
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge CLK);
                if (if_gnt[0] || dm_gnt[0]) found = 1'b1;
                else step();
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_dm = (n % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            checks++;
            if (!found) begin
                errors++;
                $display("[TB] FAIL rr_timeout grant=%0d no grant within 10 cycles", n);
            end else if ({if_gnt[0], dm_gnt[0]} !== {!exp_dm, exp_dm}) begin
                errors++;
                $display("[TB] FAIL rr_order grant=%0d if/dm got=%b exp=%b", n,
                         {if_gnt[0], dm_gnt[0]}, {!exp_dm, exp_dm});
            end
            step();
        end
        idle_inputs(0);
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_latency3();
        do_reset(1);
        dm_req[1]  = 1'b1;
        dm_addr[1] = 32'h20;
        @(negedge CLK);
        checks++;
        if (dm_gnt[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lat3_gnt got=%b exp=1", dm_gnt[1]);
        end
        step();
        idle_inputs(1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            checks++;
            if ({mem_en[1], dm_rvalid[1], busy[1]} !== {i == 1, i == 4, i <= 4}) begin
                errors++;
                $display("[TB] FAIL lat3_seq cyc=%0d en/rvalid/busy got=%b exp=%b", i,
                         {mem_en[1], dm_rvalid[1], busy[1]}, {i == 1, i == 4, i <= 4});
            end
            if (i == 4) begin
                checks++;
                if (dm_rdata[1] !== shadow[1][10'h20]) begin
                    errors++;
                    $display("[TB] FAIL lat3_rdata got=%h exp=%h", dm_rdata[1], shadow[1][10'h20]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        dm_req[1]  = 1'b1;
        dm_addr[1] = 32'h24;
        @(negedge CLK);
        checks++;
        if (dm_gnt[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_gnt got=%b exp=1", dm_gnt[1]);
        end
        step();
        idle_inputs(1);
        step();
        rst[1]     = 1'b1;
        if_req[1]  = 1'b1;
        if_addr[1] = 32'h28;
        @(negedge CLK);
        checks++;
        if (if_gnt[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_gnt_forced got=%b exp=0", if_gnt[1]);
        end
        step();
        rst[1] = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy[1] !== 1'b0 || if_gnt[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_regrant busy=%b ifgnt=%b exp 0/1", busy[1], if_gnt[1]);
        end
        step();
        if_req[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checks++;
            if (dm_rvalid[1] !== 1'b0 || if_rvalid[1] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL rstmid_rvalid cyc=%0d dm=%b if=%b exp dm=0 if=%b", i,
                         dm_rvalid[1], if_rvalid[1], i == 3);
            end
            if (i == 3) begin
                checks++;
                if (if_rdata[1] !== shadow[1][10'h28]) begin
                    errors++;
                    $display("[TB] FAIL rstmid_rdata got=%h exp=%h", if_rdata[1], shadow[1][10'h28]);
                end
            end
            step();
        end
    endtask

    // Transaction-level model: a grant is possible once the previous one has fully
    // completed (grant+2+latency); expected bus/response cycles follow from the grant cycle.
    task automatic test_random(input int k, input int ncyc);
        int            free_at;
        int            en_cyc;
        int            rv_cyc;
        bit            if_pend, dm_pend, pref_dm, g, w_dm, en_we, rv_dm, exp_en;
        logic [31:0]   en_addr, en_wdata, rv_data, last_if, last_dm, exp_if, exp_dm_d;
        free_at = 0;
        en_cyc  = -1;
        rv_cyc  = -1;
        if_pend = 1'b0;
        dm_pend = 1'b0;
        pref_dm = 1'b1;
        rv_dm   = 1'b0;
        en_we   = 1'b0;
        en_addr = '0;
        en_wdata = '0;
        rv_data = '0;
        last_if = '0;
        last_dm = '0;
        do_reset(k);
        for (int c = 0; c < ncyc; c++) begin
            if (!if_pend) if_req[k] = 1'b0;
            if (!dm_pend) dm_req[k] = 1'b0;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend    = 1'b1;
                if_req[k]  = 1'b1;
                if_addr[k] = $urandom_range(0, 1023);
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend     = 1'b1;
                dm_req[k]   = 1'b1;
                dm_we[k]    = 1'($urandom_range(0, 1));
                dm_addr[k]  = $urandom_range(0, 1023);
                dm_wdata[k] = $urandom;
            end
            g = (c >= free_at) && (if_pend || dm_pend);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_dm = (if_pend && dm_pend) ? pref_dm : dm_pend;
`else
            w_dm = dm_pend;
`endif
            exp_en   = (c == en_cyc);
            exp_if   = (c == rv_cyc && !rv_dm) ? rv_data : last_if;
            exp_dm_d = (c == rv_cyc && rv_dm) ? rv_data : last_dm;
            @(negedge CLK);
            checks++;
            if ({if_gnt[k], dm_gnt[k]} !== {g && !w_dm, g && w_dm}) begin
                errors++;
                $display("[TB] FAIL rnd_gnt k=%0d cyc=%0d if/dm got=%b exp=%b", k, c,
                         {if_gnt[k], dm_gnt[k]}, {g && !w_dm, g && w_dm});
            end
            checks++;
            if (mem_en[k] !== exp_en || busy[k] !== (c < free_at)) begin
                errors++;
                $display("[TB] FAIL rnd_en_busy k=%0d cyc=%0d en=%b busy=%b exp %b/%b", k, c,
                         mem_en[k], busy[k], exp_en, c < free_at);
            end
            checks++;
            if (exp_en ? (mem_we[k] !== en_we || mem_addr[k] !== en_addr ||
                          (en_we && mem_wdata[k] !== en_wdata))
                       : (mem_we[k] !== 1'b0 || mem_addr[k] !== '0 || mem_wdata[k] !== '0)) begin
                errors++;
                $display("[TB] FAIL rnd_cmd k=%0d cyc=%0d we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                         k, c, mem_we[k], mem_addr[k], mem_wdata[k], exp_en && en_we,
                         exp_en ? en_addr : 32'h0, (exp_en && en_we) ? en_wdata : 32'h0);
            end
            checks++;
            if ({if_rvalid[k], dm_rvalid[k]} !== {c == rv_cyc && !rv_dm, c == rv_cyc && rv_dm}) begin
                errors++;
                $display("[TB] FAIL rnd_rvalid k=%0d cyc=%0d if/dm got=%b exp=%b", k, c,
                         {if_rvalid[k], dm_rvalid[k]}, {c == rv_cyc && !rv_dm, c == rv_cyc && rv_dm});
            end
            checks++;
            if (if_rdata[k] !== exp_if || dm_rdata[k] !== exp_dm_d) begin
                errors++;
                $display("[TB] FAIL rnd_rdata k=%0d cyc=%0d if=%h dm=%h exp if=%h dm=%h", k, c,
                         if_rdata[k], dm_rdata[k], exp_if, exp_dm_d);
            end
            last_if = exp_if;
            last_dm = exp_dm_d;
            if (g) begin
                en_cyc  = c + 1;
                rv_cyc  = c + 1 + lat[k];
                free_at = c + 2 + lat[k];
                rv_dm   = w_dm;
                pref_dm = !w_dm;
                if (w_dm) begin
                    en_we    = dm_we[k];
                    en_addr  = dm_addr[k];
                    en_wdata = dm_wdata[k];
                    rv_data  = dm_we[k] ? 32'h0 : shadow[k][dm_addr[k][9:0]];
                    if (dm_we[k]) shadow[k][dm_addr[k][9:0]] = dm_wdata[k];
                    dm_pend  = 1'b0;
                end else begin
                    en_we    = 1'b0;
                    en_addr  = if_addr[k];
                    en_wdata = 32'h0;
                    rv_data  = shadow[k][if_addr[k][9:0]];
                    if_pend  = 1'b0;
                end
            end
            step();
        end
        idle_inputs(k);
        for (int i = 0; i < 6; i++) step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) shadow[k][i] = init_word(i);
            idle_inputs(k);
            rst[k] = 1'b1;
        end
        step();
        test_reset(0);
        test_reset(1);
        test_if_fetch();
        test_priority();
        test_round_robin();
        test_latency3();
        test_reset_mid();
        test_random(0, 400);
        test_random(1, 400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
